// File: rtl/imem_port_arbiter.sv
// Two-port arbiter in front of the instruction ROM's single async read port.
// Grants one requester per cycle, drives the word address and registers the returned word.
module imem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int FIX_PRIO = 0,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [31:0]       addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rerr0,
    input  logic              req1,
    input  logic [31:0]       addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rerr1,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [DATA_W-1:0] mem_spo
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [1:0]        w_req;
    logic [1:0][31:0]  w_addr;
    logic [1:0]        w_gnt;
    logic [1:0]        w_err;
    logic [ADDR_W-1:0] w_mem_a;

    logic       r_last_gnt;
    logic [3:0] r_wait_cnt;

    assign w_req  = {req1, req0};
    assign w_addr = {addr1, addr0};

    // Reset forces both grants low so a read in the reset cycle never issues.
    always_comb begin
        w_gnt = 2'b00;
        if (rst_n) begin
            unique case (w_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11: begin
                    if (FIX_PRIO != 0)
                        w_gnt = (r_wait_cnt == LP_MAX_WAIT) ? 2'b10 : 2'b01;
                    else
                        w_gnt = r_last_gnt ? 2'b01 : 2'b10;
                end
                default: w_gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        w_mem_a = '0;
        if (w_gnt[0])
            w_mem_a = addr0[ADDR_W+1:2];
        else if (w_gnt[1])
            w_mem_a = addr1[ADDR_W+1:2];
    end

    assign gnt0  = w_gnt[0];
    assign gnt1  = w_gnt[1];
    assign mem_a = w_mem_a;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
            r_wait_cnt <= 4'd0;
        end else begin
            if (|w_gnt)
                r_last_gnt <= w_gnt[1];
            // Starvation count only matters under fixed priority; saturates at the force-grant point.
            if (FIX_PRIO == 0 || w_gnt[1])
                r_wait_cnt <= 4'd0;
            else if (req1 && r_wait_cnt != LP_MAX_WAIT)
                r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            logic              r_rvalid;
            logic [DATA_W-1:0] r_rdata;
            logic              r_rerr;

            assign w_err[gi] = (w_addr[gi][1:0] != 2'b00) | (|w_addr[gi][31:ADDR_W+2]);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                    r_rerr   <= 1'b0;
                end else begin
                    r_rvalid <= w_gnt[gi];
                    if (w_gnt[gi]) begin
                        r_rdata <= w_err[gi] ? '0 : mem_spo;
                        r_rerr  <= w_err[gi];
                    end
                end
            end
        end
    endgenerate

    assign rvalid0 = gen_port[0].r_rvalid;
    assign rdata0  = gen_port[0].r_rdata;
    assign rerr0   = gen_port[0].r_rerr;
    assign rvalid1 = gen_port[1].r_rvalid;
    assign rdata1  = gen_port[1].r_rdata;
    assign rerr1   = gen_port[1].r_rerr;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: round-robin and fixed-priority instances share stimulus;
// a vector table drives grants/addresses, a response scoreboard checks the registered words.
module tb_imem_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] addr0, addr1;

    logic [1:0]        gnt0_w, gnt1_w, rvalid0_w, rvalid1_w, rerr0_w, rerr1_w;
    logic [DATA_W-1:0] rdata0_w [2];
    logic [DATA_W-1:0] rdata1_w [2];
    logic [ADDR_W-1:0] mem_a_w [2];
    logic [DATA_W-1:0] mem_spo_w [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [13:0] a);
        return 32'h2001_0001 + {18'd0, a};
    endfunction

    assign mem_spo_w[0] = rom_word(mem_a_w[0]);
    assign mem_spo_w[1] = rom_word(mem_a_w[1]);

    imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIX_PRIO(0), .MAX_WAIT(4)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0_w[0]), .rvalid0(rvalid0_w[0]), .rdata0(rdata0_w[0]), .rerr0(rerr0_w[0]),
        .req1(req1), .addr1(addr1), .gnt1(gnt1_w[0]), .rvalid1(rvalid1_w[0]), .rdata1(rdata1_w[0]), .rerr1(rerr1_w[0]),
        .mem_a(mem_a_w[0]), .mem_spo(mem_spo_w[0])
    );

    imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIX_PRIO(1), .MAX_WAIT(4)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0_w[1]), .rvalid0(rvalid0_w[1]), .rdata0(rdata0_w[1]), .rerr0(rerr0_w[1]),
        .req1(req1), .addr1(addr1), .gnt1(gnt1_w[1]), .rvalid1(rvalid1_w[1]), .rdata1(rdata1_w[1]), .rerr1(rerr1_w[1]),
        .mem_a(mem_a_w[1]), .mem_spo(mem_spo_w[1])
    );

    typedef struct {
        logic        rst_n;
        logic        req0;
        logic [31:0] addr0;
        logic        req1;
        logic [31:0] addr1;
        logic [1:0]  g_rr;   // expected {gnt1,gnt0}, round-robin instance
        logic [1:0]  g_fp;   // expected {gnt1,gnt0}, fixed-priority instance
    } vec_t;

    typedef struct {
        int          cyc;
        int          dut;
        int          port;
        logic [31:0] data;
        logic        err;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb_q[$];

    logic [31:0] held_data [2][2];
    logic        held_err  [2][2];
    logic        rst_pend;

    task automatic add(input logic r, input logic q0, input logic [31:0] a0,
                       input logic q1, input logic [31:0] a1,
                       input logic [1:0] grr, input logic [1:0] gfp);
        vec_t v;
        v.rst_n = r; v.req0 = q0; v.addr0 = a0; v.req1 = q1; v.addr1 = a1;
        v.g_rr = grr; v.g_fp = gfp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:16] != 16'd0);
    endfunction

    // One cycle: drive just after the rising edge, check at the falling edge.
    task automatic step(input vec_t v);
        logic [1:0]  g_exp;
        logic [13:0] a_exp;
        logic        vexp [2][2];
        logic [31:0] ad;
        int          p;
        rst_n = v.rst_n; req0 = v.req0; addr0 = v.addr0; req1 = v.req1; addr1 = v.addr1;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int q = 0; q < 2; q++) begin
                vexp[d][q] = 1'b0;
                if (rst_pend) begin
                    held_data[d][q] = 32'd0;
                    held_err[d][q]  = 1'b0;
                end
            end
        rst_pend = 1'b0;
        while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            resp_t e;
            e = sb_q.pop_front();
            vexp[e.dut][e.port]      = 1'b1;
            held_data[e.dut][e.port] = e.data;
            held_err[e.dut][e.port]  = e.err;
        end
        for (int d = 0; d < 2; d++) begin
            g_exp = (d == 0) ? v.g_rr : v.g_fp;
            a_exp = g_exp[0] ? v.addr0[15:2] : (g_exp[1] ? v.addr1[15:2] : 14'd0);
            check($sformatf("d%0d_gnt", d), {30'd0, gnt1_w[d], gnt0_w[d]}, {30'd0, g_exp});
            check($sformatf("d%0d_mem_a", d), {18'd0, mem_a_w[d]}, {18'd0, a_exp});
            check($sformatf("d%0d_rvalid0", d), {31'd0, rvalid0_w[d]}, {31'd0, vexp[d][0]});
            check($sformatf("d%0d_rvalid1", d), {31'd0, rvalid1_w[d]}, {31'd0, vexp[d][1]});
            check($sformatf("d%0d_rdata0", d), rdata0_w[d], held_data[d][0]);
            check($sformatf("d%0d_rdata1", d), rdata1_w[d], held_data[d][1]);
            check($sformatf("d%0d_rerr0", d), {31'd0, rerr0_w[d]}, {31'd0, held_err[d][0]});
            check($sformatf("d%0d_rerr1", d), {31'd0, rerr1_w[d]}, {31'd0, held_err[d][1]});
            if (v.rst_n && g_exp != 2'b00) begin
                resp_t e;
                p  = g_exp[1] ? 1 : 0;
                ad = (p == 1) ? v.addr1 : v.addr0;
                e.cyc = cyc + 1; e.dut = d; e.port = p;
                e.err  = addr_err(ad);
                e.data = e.err ? 32'd0 : rom_word(ad[15:2]);
                sb_q.push_back(e);
            end
        end
        if (!v.rst_n) rst_pend = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        vec_t hv;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = 32'd0; addr1 = 32'd0;
        rst_pend = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int q = 0; q < 2; q++) begin
                held_data[d][q] = 32'd0;
                held_err[d][q]  = 1'b0;
            end

        // Reset held with both requesting, then first tie goes to port 0.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 2'b00, 2'b00);
        add(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 2'b01, 2'b01);
        // Single port 0 read of ROM[4].
        add(1'b1, 1'b1, 32'h10, 1'b0, 32'h0,  2'b01, 2'b01);
        add(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  2'b00, 2'b00);
        // Fresh reset, then continuous tie: alternation vs. 4-then-1 starvation pattern.
        add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  2'b00, 2'b00);
        add(1'b1, 1'b1, 32'h100, 1'b1, 32'h204, 2'b01, 2'b01);
        add(1'b1, 1'b1, 32'h100, 1'b1, 32'h204, 2'b10, 2'b01);
        add(1'b1, 1'b1, 32'h100, 1'b1, 32'h204, 2'b01, 2'b01);
        add(1'b1, 1'b1, 32'h100, 1'b1, 32'h204, 2'b10, 2'b01);
        add(1'b1, 1'b1, 32'h100, 1'b1, 32'h204, 2'b01, 2'b10);
        add(1'b1, 1'b1, 32'h100, 1'b1, 32'h204, 2'b10, 2'b01);
        add(1'b1, 1'b1, 32'h100, 1'b1, 32'h204, 2'b01, 2'b01);
        add(1'b1, 1'b1, 32'h100, 1'b1, 32'h204, 2'b10, 2'b01);
        add(1'b1, 1'b1, 32'h100, 1'b1, 32'h204, 2'b01, 2'b01);
        add(1'b1, 1'b1, 32'h100, 1'b1, 32'h204, 2'b10, 2'b10);
        add(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  2'b00, 2'b00);
        // Address errors on port 1, then a clean aligned read of ROM[2].
        add(1'b1, 1'b0, 32'h0,  1'b1, 32'h0000_0006, 2'b10, 2'b10);
        add(1'b1, 1'b0, 32'h0,  1'b1, 32'h0001_0000, 2'b10, 2'b10);
        add(1'b1, 1'b0, 32'h0,  1'b1, 32'h0000_0008, 2'b10, 2'b10);
        add(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  2'b00, 2'b00);
        // Build up starvation count, reset while port 1 requests, check the count restarted.
        add(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 2'b01, 2'b01);
        add(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 2'b10, 2'b01);
        add(1'b0, 1'b0, 32'h0,  1'b1, 32'h80, 2'b00, 2'b00);
        add(1'b1, 1'b1, 32'h44, 1'b1, 32'h84, 2'b01, 2'b01);
        add(1'b1, 1'b1, 32'h44, 1'b1, 32'h84, 2'b10, 2'b01);
        add(1'b1, 1'b1, 32'h44, 1'b1, 32'h84, 2'b01, 2'b01);
        add(1'b1, 1'b1, 32'h44, 1'b1, 32'h84, 2'b10, 2'b01);
        add(1'b1, 1'b1, 32'h44, 1'b1, 32'h84, 2'b01, 2'b10);
        add(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  2'b00, 2'b00);

        @(posedge clk);
        #1;
        foreach (vecs[i]) step(vecs[i]);

        // Back-to-back port 0 reads with a new address every cycle (full throughput).
        for (int i = 0; i < 5; i++) begin
            hv.rst_n = 1'b1; hv.req0 = 1'b1; hv.addr0 = 32'h200 + 32'(i * 4);
            hv.req1 = 1'b0; hv.addr1 = 32'h0; hv.g_rr = 2'b01; hv.g_fp = 2'b01;
            step(hv);
        end
        // Port 1 request withdrawn while port 0 holds the port: no port 1 response.
        hv.addr0 = 32'h300; hv.req1 = 1'b1; hv.addr1 = 32'h304; hv.g_rr = 2'b10; hv.g_fp = 2'b01;
        step(hv);
        hv.req0 = 1'b0; hv.req1 = 1'b0; hv.g_rr = 2'b00; hv.g_fp = 2'b00;
        step(hv);
        step(hv);

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0 pending responses", sb_q.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single combinational read port of the 64KB instruction ROM (14-bit word address, 32-bit async read data) between two requesters.
  - Port 0: pipeline instruction fetch.
  - Port 1: debug/loader read-back, or data-side loads from code space.
- Grants at most one requester per cycle and drives the ROM word address.
- Registers the returned word with a fixed 1-cycle latency.
- Supports round-robin or fixed-priority arbitration, with a starvation guard for port 1.

Parameters:
- ADDR_W, 14, ROM word-address width (ROM depth 2^ADDR_W words).
- DATA_W, 32, ROM data width.
- FIX_PRIO, 0, 0 = round-robin; 1 = port 0 has fixed priority.
- MAX_WAIT, 4, in FIX_PRIO mode: consecutive denied cycles of port 1 before it is force-granted. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0  in  1  port 0 request.
- addr0  in  32  port 0 byte address.
- gnt0  out  1  port 0 grant (combinational).
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DATA_W  port 0 read data.
- rerr0  out  1  port 0 address error, qualified by rvalid0.
- req1, addr1, gnt1, rvalid1, rdata1, rerr1: same as port 0, for port 1.
- mem_a  out  ADDR_W  ROM word address.
- mem_spo  in  DATA_W  ROM async read data.

Behaviour:
- Reset (rst_n low at a clk edge):
  - rvalid0/1 = 0, rdata0/1 = 0, rerr0/1 = 0.
  - last_gnt = 1, so port 0 wins the first tie.
  - wait_cnt = 0.
  - While rst_n is low: gnt0 = gnt1 = 0 and mem_a = 0.
  - A read granted in the cycle reset is asserted is discarded; no rvalid follows.
- Grant (combinational, same cycle as req):
  - Only req0: gnt0. Only req1: gnt1. Neither: no grant, mem_a = 0.
  - Both, FIX_PRIO = 0: grant the port that is not last_gnt. last_gnt updates at every edge where a grant occurred.
  - Both, FIX_PRIO = 1: gnt0, unless wait_cnt == MAX_WAIT, in which case gnt1.
  - gnt0 and gnt1 are never both high.
- Starvation counter wait_cnt (4 bits):
  - FIX_PRIO = 1 only: increments at each edge with req1 & !gnt1, saturating at MAX_WAIT; clears at each edge with gnt1.
  - FIX_PRIO = 0: held at 0.
- Address path:
  - mem_a = addrN[ADDR_W+1:2] of the granted port.
  - addrN is sampled only in the grant cycle. The requester holds req and addr stable until gnt and may change them the cycle after.
- Response path:
  - At the edge ending a grant cycle: rdataN <= mem_spo, rvalidN <= 1.
  - rvalidN is a 1-cycle pulse; it stays high on consecutive cycles only if the port is granted back-to-back.
  - rdataN holds its value until the next response to that port.
  - The non-granted port's rvalid is 0.
  - Back-to-back grants to the same port give one word per cycle (full throughput).
- Address error:
  - Condition: addrN[1:0] != 0, or any bit of addrN[31:ADDR_W+2] set.
  - Such a request is still granted, and mem_a is still driven.
  - The response is rdataN = 0 and rerrN = 1 together with rvalidN.
  - rerrN clears with the next response to that port.
- Simultaneous reset and request: reset wins.
- Requests withdrawn before grant are legal; no response is produced.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with req0 = req1 = 1 -> gnt0 = gnt1 = 0, mem_a = 0, all rvalid/rdata/rerr = 0. Release -> gnt0 in the first cycle.
- Single port: req0 = 1, addr0 = 0x0000_0010, ROM[4] = 0x2001_0005 -> gnt0 in cycle 0, mem_a = 4; rvalid0 = 1 with rdata0 = 0x2001_0005 in cycle 1. rvalid1 stays 0 throughout.
- Round-robin (FIX_PRIO = 0): req0 = req1 = 1 continuously for 6 cycles -> grants alternate 0,1,0,1,0,1. Each rvalid follows its grant by 1 cycle with the correct words.
- Fixed priority with starvation guard (FIX_PRIO = 1, MAX_WAIT = 4): req0 = req1 = 1 continuously -> gnt0 for 4 cycles, gnt1 in cycle 5, gnt0 again in cycle 6. The pattern repeats every 5 cycles.
- Address error: req1 = 1, addr1 = 0x0000_0006 (misaligned), then addr1 = 0x0001_0000 (out of range) -> rvalid1 = 1, rerr1 = 1, rdata1 = 0 for each. A following aligned addr1 = 0x0000_0008 gives rerr1 = 0 and rdata1 = ROM[2].
- Reset mid-operation: grant port 1 in cycle N with rst_n = 0 at the same edge -> no rvalid1 in cycle N+1. In FIX_PRIO = 1, wait_cnt returns to 0 and port 0 wins the next tie.
